// File: rtl/vend_pkg.sv
// vend_pkg: shared state, coin codes and cents types for the vend transaction controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  typedef logic [8:0] cents_t;
  localparam logic [1:0] COIN_NICKEL  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;
  localparam logic [1:0] COIN_DOLLAR  = 2'b11;
  localparam logic [6:0] NICKEL_CENTS  = 7'd5;
  localparam logic [6:0] DIME_CENTS    = 7'd10;
  localparam logic [6:0] QUARTER_CENTS = 7'd25;
  localparam logic [6:0] DOLLAR_CENTS  = 7'd100;
endpackage

// File: rtl/vend_coin_decoder.sv
// vend_coin_decoder: maps a coin_type code to its value in cents
module vend_coin_decoder
  import vend_pkg::*;
(
  input  logic [1:0] coin_type,
  output logic [6:0] cents
);
  always_comb
    cents = coin_type == COIN_NICKEL  ? NICKEL_CENTS  :
            coin_type == COIN_DIME    ? DIME_CENTS    :
            coin_type == COIN_QUARTER ? QUARTER_CENTS : DOLLAR_CENTS;
endmodule

// File: rtl/vend_transaction_ctrl.sv
// vend_transaction_ctrl: coin credit, selection latch, dispense handshake with timeout, change return
module vend_transaction_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT     = 500,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_valid,
  input  logic [5:0] selection,
  input  logic [8:0] price,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       dispense_ack,
  input  logic       change_ack,
  output logic [8:0] credit,
  output logic       coin_reject,
  output logic       sel_invalid,
  output logic       dispense_req,
  output logic [5:0] dispense_sel,
  output logic       change_valid,
  output logic [8:0] change_amount,
  output logic       vend_done,
  output logic       vend_fault,
  output logic       busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t      state, state_n;
  cents_t      credit_n, price_l, price_n, change_n, refund;
  logic [5:0]  sel_l, sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]  coin_cents;
  logic [9:0]  sum;
  logic        open, coin_ok, delivered, deliv_n, rej_n, inv_n, done_n, fault_n;
  vend_coin_decoder u_dec (.coin_type(coin_type), .cents(coin_cents));
  assign dispense_req = state == DISPENSE;
  assign change_valid = state == CHANGE;
  assign busy         = dispense_req || change_valid;
  assign dispense_sel = dispense_req ? sel_l : '0;
  assign open         = state == IDLE || state == COLLECT;
  assign sum          = {1'b0, credit} + {3'b0, coin_cents};
  assign coin_ok      = coin_valid && open && !cancel && sum <= 10'(MAX_CREDIT);
  assign refund       = credit - price_l;
  always_comb begin
    state_n  = state;
    credit_n = coin_ok ? sum[8:0] : credit;
    sel_n    = sel_l;
    price_n  = price_l;
    cnt_n    = '0;
    change_n = change_amount;
    deliv_n  = delivered;
    rej_n    = coin_valid && !coin_ok;
    inv_n    = 1'b0;
    done_n   = 1'b0;
    fault_n  = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (cancel) begin
          state_n  = credit != '0 ? CHANGE : IDLE;
          change_n = credit;
          deliv_n  = 1'b0;
          sel_n    = credit != '0 ? sel_l : '0;
          price_n  = credit != '0 ? price_l : '0;
        end else if (state == COLLECT && credit >= price_l) begin
          state_n = DISPENSE;
        end else if (sel_valid) begin
          inv_n   = price == '0;
          state_n = price != '0 ? COLLECT : state;
          sel_n   = price != '0 ? selection : sel_l;
          price_n = price != '0 ? price : price_l;
        end
      end
      DISPENSE: begin
        cnt_n = cnt + 1'b1;
        if (dispense_ack) begin
          change_n = refund;
          deliv_n  = 1'b1;
          done_n   = refund == '0;
          state_n  = refund != '0 ? CHANGE : IDLE;
          credit_n = refund != '0 ? credit : '0;
          sel_n    = refund != '0 ? sel_l : '0;
          price_n  = refund != '0 ? price_l : '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          fault_n  = 1'b1;
          change_n = credit;
          deliv_n  = 1'b0;
          state_n  = CHANGE;
        end
      end
      CHANGE: begin
        if (change_ack) begin
          state_n  = IDLE;
          credit_n = '0;
          sel_n    = '0;
          price_n  = '0;
          change_n = '0;
          done_n   = delivered;
          deliv_n  = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      credit        <= '0;
      sel_l         <= '0;
      price_l       <= '0;
      cnt           <= '0;
      change_amount <= '0;
      delivered     <= 1'b0;
      coin_reject   <= 1'b0;
      sel_invalid   <= 1'b0;
      vend_done     <= 1'b0;
      vend_fault    <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      sel_l         <= sel_n;
      price_l       <= price_n;
      cnt           <= cnt_n;
      change_amount <= change_n;
      delivered     <= deliv_n;
      coin_reject   <= rej_n;
      sel_invalid   <= inv_n;
      vend_done     <= done_n;
      vend_fault    <= fault_n;
    end
  end
endmodule
